// File: rtl/sha256_msg_schedule_pkg.sv
// Shared definitions for the SHA-256 message schedule generator.
// Holds the SHA-256 geometry, the two FSM state encodings, the small-sigma
// rotate/shift amounts and a rotate-right helper.
package sha256_msg_schedule_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned ROUNDS  = 64;
  localparam int unsigned WIN     = 16;

  typedef logic [WORD_W-1:0] word_t;

  // Index of the final schedule word
  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  // FSM state encodings
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // sha256_sigma_small mode select
  localparam logic SIGMA0 = 1'b0;
  localparam logic SIGMA1 = 1'b1;

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  localparam int unsigned S0_ROT_A = 7;
  localparam int unsigned S0_ROT_B = 18;
  localparam int unsigned S0_SHR   = 3;
  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  localparam int unsigned S1_ROT_A = 17;
  localparam int unsigned S1_ROT_B = 19;
  localparam int unsigned S1_SHR   = 10;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/add4.sv
// Four-input 32-bit adder, sum truncated modulo 2^32.
// Ports: a_i, b_i, c_i, d_i operands; sum_o = a_i + b_i + c_i + d_i.
module add4 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] sum_o
);

  assign sum_o = a_i + b_i + c_i + d_i;

endmodule

// File: rtl/sha256_sigma_small.sv
// SHA-256 small sigma function, combinational.
// Ports: mode_i selects sigma0 (SIGMA0) or sigma1 (SIGMA1); x_i input word;
//        y_o result word.
module sha256_sigma_small
  import sha256_msg_schedule_pkg::*;
(
  input  logic  mode_i,
  input  word_t x_i,
  output word_t y_o
);

  always_comb begin
    if (mode_i == SIGMA1) begin
      y_o = rotr(x_i, S1_ROT_A) ^ rotr(x_i, S1_ROT_B) ^ (x_i >> S1_SHR);
    end else begin
      y_o = rotr(x_i, S0_ROT_A) ^ rotr(x_i, S0_ROT_B) ^ (x_i >> S0_SHR);
    end
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule generator.
// Accepts one padded 512-bit block in IDLE and streams W[0..63], one word per
// w_valid/w_ready handshake, from a 16-word sliding window.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   blk_valid/blk_ready   block handshake (ready only in IDLE)
//   blk_data              block, [511:480] = M0 ... [31:0] = M15
//   w_valid/w_ready       word handshake
//   w_data, w_idx, w_last current word W[t], t, and t == 63 flag
module sha256_msg_schedule
  import sha256_msg_schedule_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLOCK_W-1:0] blk_data,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [WORD_W-1:0]  w_data,
  output logic [5:0]         w_idx,
  output logic               w_last
);

  logic [0:0] state_q, state_d;
  logic [5:0] t_q, t_d;
  word_t      win_q [WIN];
  word_t      win_d [WIN];

  word_t s0_val, s1_val, w_next;

  sha256_sigma_small u_sigma0 (
    .mode_i (SIGMA0),
    .x_i    (win_q[1]),
    .y_o    (s0_val)
  );

  sha256_sigma_small u_sigma1 (
    .mode_i (SIGMA1),
    .x_i    (win_q[14]),
    .y_o    (s1_val)
  );

  // r[15]' = s1(r[14]) + r[9] + s0(r[1]) + r[0]
  add4 u_add4 (
    .a_i   (s1_val),
    .b_i   (win_q[9]),
    .c_i   (s0_val),
    .d_i   (win_q[0]),
    .sum_o (w_next)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    for (int i = 0; i < WIN; i++) begin
      win_d[i] = win_q[i];
    end

    if (state_q == S_IDLE) begin
      if (blk_valid) begin
        for (int i = 0; i < WIN; i++) begin
          win_d[i] = blk_data[BLOCK_W - 1 - WORD_W * i -: WORD_W];
        end
        t_d     = '0;
        state_d = S_RUN;
      end
    end else if (w_ready) begin
      for (int i = 0; i < WIN - 1; i++) begin
        win_d[i] = win_q[i + 1];
      end
      win_d[WIN - 1] = w_next;
      // Wraps 63 -> 0, leaving w_idx at 0 back in IDLE
      t_d = t_q + 6'd1;
      if (t_q == LAST_T) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Outputs decode state registers only; no path from w_ready/blk_valid.
  assign blk_ready = (state_q == S_IDLE);
  assign w_valid   = (state_q == S_RUN);
  assign w_data    = win_q[0];
  assign w_idx     = t_q;
  assign w_last    = (state_q == S_RUN) && (t_q == LAST_T);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Testbench for sha256_msg_schedule: a reference model expands each accepted
// block into 64 expected words queued on a scoreboard; a monitor on the
// falling edge compares every presented word against the queue head.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .w_last    (w_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  idx;
    logic        last;
    int          first_cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] dut_w[64];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_hs = 0;
  int          last63_cyc = -1;
  bit          seen0 = 1'b0;
  bit          b2b_chk = 1'b0;
  int          rmode = 0;
  int          stall = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Textbook schedule expansion over the whole 64-word array
  task automatic push_block(input logic [511:0] b, input int hc);
    logic [31:0] w[64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.data = w[t];
      e.idx = 6'(t);
      e.last = (t == 63);
      e.first_cyc = (t == 0) ? hc : -1;
      q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns #1 after the handshake edge
  task automatic send_block(input logic [511:0] b, input bit hold);
    int n = 0;
    blk_valid = 1'b1;
    blk_data = b;
    do begin
      @(negedge clk);
      n++;
    end while (!blk_ready && n < 1000);
    if (!blk_ready) begin
      total++;
      bad++;
      $display("FAIL blk_handshake_timeout: got=blk_ready low expected=high");
      blk_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_hs = cyc;
    push_block(b, cyc);
    if (!hold) blk_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || !blk_ready) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL stream_timeout: got=%0d words pending expected=0", q.size());
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32 * i +: 32] = $urandom;
    return b;
  endfunction

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("w_valid", 64'(w_valid), 64'(q.size() != 0));
      check("blk_ready", 64'(blk_ready), 64'(q.size() == 0));
      if (w_valid && q.size() != 0) begin
        check("w_data", 64'(w_data), 64'(q[0].data));
        check("w_idx", 64'(w_idx), 64'(q[0].idx));
        check("w_last", 64'(w_last), 64'(q[0].last));
        if (q[0].idx == 6'd0 && !seen0) begin
          seen0 = 1'b1;
          if (q[0].first_cyc >= 0) check("w0_latency", 64'(cyc), 64'(q[0].first_cyc));
          if (b2b_chk) begin
            check("b2b_gap", 64'(cyc), 64'(last63_cyc + 2));
            b2b_chk = 1'b0;
          end
        end
        if (w_ready) begin
          dut_w[w_idx] = w_data;
          if (w_idx == 6'd63) last63_cyc = cyc;
          void'(q.pop_front());
          seen0 = 1'b0;
        end
      end
    end
  end

  // Consumer ready driver
  initial forever begin
    @(posedge clk);
    #1;
    if (rmode == 0) begin
      w_ready = 1'b1;
    end else if (w_valid && w_idx == 6'd16 && stall < 5) begin
      w_ready = 1'b0;
      stall++;
    end else begin
      w_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [511:0] abc;
    logic [511:0] ones;
    int n;
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0] = 32'h00000018;
    ones = '1;

    // Reset values
    #1;
    check("rst_blk_ready", 64'(blk_ready), 64'd1);
    check("rst_w_valid", 64'(w_valid), 64'd0);
    check("rst_w_data", 64'(w_data), 64'd0);
    check("rst_w_idx", 64'(w_idx), 64'd0);
    check("rst_w_last", 64'(w_last), 64'd0);
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: "abc" block, ready held high
    rmode = 0;
    send_block(abc, 1'b0);
    wait_done();
    check("abc_w0", 64'(dut_w[0]), 64'h61626380);
    check("abc_w15", 64'(dut_w[15]), 64'h00000018);
    check("abc_w16", 64'(dut_w[16]), 64'h61626380);
    check("abc_w17", 64'(dut_w[17]), 64'h000f0000);
    check("w63_latency", 64'(last63_cyc), 64'(last_hs + 63));

    // 2: same block with random backpressure and a 5-cycle stall at t=16
    rmode = 1;
    stall = 0;
    send_block(abc, 1'b0);
    wait_done();
    check("stall_at_16", 64'(stall), 64'd5);

    // 3: back-to-back blocks with blk_valid held
    rmode = 0;
    send_block(rand_block(), 1'b1);
    b2b_chk = 1'b1;
    send_block(rand_block(), 1'b0);
    wait_done();

    // 4: all-ones block
    send_block(ones, 1'b0);
    wait_done();

    // 5: asynchronous reset mid-block at t=30
    rmode = 1;
    send_block(rand_block(), 1'b0);
    n = 0;
    while (!(w_valid && w_idx == 6'd30) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_t30", 64'(w_idx), 64'd30);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_w_valid", 64'(w_valid), 64'd0);
    check("arst_blk_ready", 64'(blk_ready), 64'd1);
    check("arst_w_data", 64'(w_data), 64'd0);
    check("arst_w_idx", 64'(w_idx), 64'd0);
    check("arst_w_last", 64'(w_last), 64'd0);
    q.delete();
    seen0 = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_blk_ready", 64'(blk_ready), 64'd1);
    send_block(rand_block(), 1'b0);
    wait_done();

    // 6: blk_valid pulsed during RUN with other data
    rmode = 0;
    send_block(rand_block(), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    blk_valid = 1'b1;
    blk_data = rand_block();
    repeat (3) @(posedge clk);
    #1;
    blk_valid = 1'b0;
    wait_done();

    // A few more random blocks under random backpressure
    rmode = 1;
    for (int k = 0; k < 3; k++) begin
      send_block(rand_block(), 1'b0);
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
